// File: rtl/analog_rx.sv
// rtl/analog_rx.sv - spin loader and load/compute sequencer for the analog Ising macro
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   en_i                           block enable; low forces IDLE and gates all strobes
//   rx_configure_enable_i          config write strobe for the two phase lengths
//   load_cycle_num_i               LOAD phase length in cycles (0 acts as 1)
//   cmpt_cycle_num_i               CMPT phase length in cycles (0 acts as 1)
//   spin_valid_i / spin_ready_o    spin handshake from the digital core
//   spin_i                         spin vector from the digital core
//   analog_spin_o                  spins driven to the macro
//   analog_spin_load_o             macro spin-load strobe (LOAD phase)
//   analog_cmpt_en_o               macro compute enable (CMPT phase)
//   analog_macro_cmpt_finish_o     one-cycle finish pulse to the TX stage
//   analog_tx_idle_i               TX stage idle
//   analog_rx_idle_o               high only in IDLE

module analog_rx #(
    parameter int NUM_SPIN               = 256,
    parameter int CYCLE_W                = 16,
    parameter int SYNCHRONIZER_PIPEDEPTH = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                rx_configure_enable_i,
    input  logic [CYCLE_W-1:0]  load_cycle_num_i,
    input  logic [CYCLE_W-1:0]  cmpt_cycle_num_i,
    input  logic                spin_valid_i,
    output logic                spin_ready_o,
    input  logic [NUM_SPIN-1:0] spin_i,
    output logic [NUM_SPIN-1:0] analog_spin_o,
    output logic                analog_spin_load_o,
    output logic                analog_cmpt_en_o,
    output logic                analog_macro_cmpt_finish_o,
    input  logic                analog_tx_idle_i,
    output logic                analog_rx_idle_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMPT,
        S_FINISH,
        S_HOLD
    } state_e;

    localparam logic [CYCLE_W-1:0] ONE      = CYCLE_W'(1);
    // The TX stage needs PIPEDEPTH cycles to raise its valid after the finish
    // pulse; one extra cycle keeps us from sampling a stale tx_idle.
    localparam logic [CYCLE_W-1:0] HOLD_LEN = CYCLE_W'(SYNCHRONIZER_PIPEDEPTH + 1);

    state_e              state_q, state_d;
    logic [CYCLE_W-1:0]  cnt_q, cnt_d;
    logic [CYCLE_W-1:0]  load_cfg_q, cmpt_cfg_q;
    logic [NUM_SPIN-1:0] spin_q;
    logic [CYCLE_W-1:0]  load_len, cmpt_len;
    logic                handshake;

    // A programmed length of zero behaves as a single cycle.
    assign load_len  = (load_cfg_q == '0) ? ONE : load_cfg_q;
    assign cmpt_len  = (cmpt_cfg_q == '0) ? ONE : cmpt_cfg_q;
    assign handshake = spin_valid_i & spin_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        state_d = S_LOAD;
                        cnt_d   = load_len;
                    end
                end
                S_LOAD: begin
                    // The CMPT length is sampled here, so a config write that
                    // lands during LOAD still applies to this run's CMPT.
                    if (cnt_q == ONE) begin
                        state_d = S_CMPT;
                        cnt_d   = cmpt_len;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_CMPT: begin
                    if (cnt_q == ONE) begin
                        state_d = S_FINISH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_FINISH: begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LEN;
                end
                S_HOLD: begin
                    if (cnt_q == ONE) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_cfg_q <= '1;
            cmpt_cfg_q <= '1;
        end else if (en_i && rx_configure_enable_i) begin
            load_cfg_q <= load_cycle_num_i;
            cmpt_cfg_q <= cmpt_cycle_num_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spin_q <= '0;
        end else if (handshake) begin
            spin_q <= spin_i;
        end
    end

    // Strobes are gated by en_i so that dropping enable silences the macro
    // in the same cycle rather than one cycle later.
    assign spin_ready_o               = (state_q == S_IDLE)   & en_i & analog_tx_idle_i;
    assign analog_spin_load_o         = (state_q == S_LOAD)   & en_i;
    assign analog_cmpt_en_o           = (state_q == S_CMPT)   & en_i;
    assign analog_macro_cmpt_finish_o = (state_q == S_FINISH) & en_i;
    assign analog_rx_idle_o           = (state_q == S_IDLE);
    assign analog_spin_o              = spin_q;

endmodule

// File: tb/tb_analog_rx.sv
// tb/tb_analog_rx.sv - randomized and directed self-checking bench for analog_rx

module tb_analog_rx;

    localparam int NS = 32;
    localparam int CW = 8;
    localparam int PD = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, cfg_we, valid, tx_idle;
    logic [CW-1:0] load_n, cmpt_n;
    logic [NS-1:0] spin;
    logic          ready, load_o, cmpt_o, fin_o, idle_o;
    logic [NS-1:0] aspin;

    always #5 clk = ~clk;

    analog_rx #(
        .NUM_SPIN              (NS),
        .CYCLE_W               (CW),
        .SYNCHRONIZER_PIPEDEPTH(PD)
    ) dut (
        .clk_i                     (clk),
        .rst_ni                    (rst_n),
        .en_i                      (en),
        .rx_configure_enable_i     (cfg_we),
        .load_cycle_num_i          (load_n),
        .cmpt_cycle_num_i          (cmpt_n),
        .spin_valid_i              (valid),
        .spin_ready_o              (ready),
        .spin_i                    (spin),
        .analog_spin_o             (aspin),
        .analog_spin_load_o        (load_o),
        .analog_cmpt_en_o          (cmpt_o),
        .analog_macro_cmpt_finish_o(fin_o),
        .analog_tx_idle_i          (tx_idle),
        .analog_rx_idle_o          (idle_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a run is described by the offset k (cycles since the
    // accepting handshake) and its effective phase lengths.
    bit            busy;
    int            k, n_eff, m_eff;
    logic [CW-1:0] load_cfg, cmpt_cfg;
    logic [NS-1:0] spin_exp;

    // Observation bookkeeping for directed checks.
    int cyc = 0;
    int hs_cyc, fin_cyc, load_cnt, cmpt_cnt, fin_cnt, ready_cnt;

    function automatic int max1(input logic [CW-1:0] x);
        return (x == 0) ? 1 : int'(x);
    endfunction

    task automatic model_reset();
        busy     = 1'b0;
        k        = 0;
        load_cfg = '1;
        cmpt_cfg = '1;
        spin_exp = '0;
    endtask

    task automatic clear_obs();
        load_cnt  = 0;
        cmpt_cnt  = 0;
        fin_cnt   = 0;
        ready_cnt = 0;
        hs_cyc    = -1;
        fin_cyc   = -1;
    endtask

    // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
    task automatic run_cycle();
        int  ph;
        bit  exp_ready, hs;
        #2;
        if (!busy)                     ph = 0;
        else if (k <= n_eff)           ph = 1;
        else if (k <= n_eff + m_eff)   ph = 2;
        else if (k == n_eff + m_eff + 1) ph = 3;
        else                           ph = 4;
        exp_ready = !busy && en && tx_idle;
        check_eq("ready", 64'(ready), 64'(exp_ready));
        check_eq("load",  64'(load_o), 64'(en && ph == 1));
        check_eq("cmpt",  64'(cmpt_o), 64'(en && ph == 2));
        check_eq("finish", 64'(fin_o), 64'(en && ph == 3));
        check_eq("rx_idle", 64'(idle_o), 64'(!busy));
        check_eq("spin_out", 64'(aspin), 64'(spin_exp));
        check_eq("strobe_excl", 64'((32'(load_o) + 32'(cmpt_o) + 32'(fin_o)) <= 1), 64'(1));

        load_cnt  += int'(load_o);
        cmpt_cnt  += int'(cmpt_o);
        ready_cnt += int'(ready);
        if (fin_o) begin
            fin_cnt++;
            fin_cyc = cyc;
        end

        hs = exp_ready && valid;
        if (!en) begin
            busy = 1'b0;
        end else if (!busy) begin
            if (hs) begin
                busy     = 1'b1;
                k        = 1;
                n_eff    = max1(load_cfg);
                spin_exp = spin;
                hs_cyc   = cyc;
            end
        end else begin
            if (k == n_eff) m_eff = max1(cmpt_cfg);
            k++;
            if (k > n_eff + m_eff + PD + 2) busy = 1'b0;
        end
        if (en && cfg_we) begin
            load_cfg = load_n;
            cmpt_cfg = cmpt_n;
        end

        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic configure(input int n, input int m);
        cfg_we = 1'b1;
        load_n = CW'(n);
        cmpt_n = CW'(m);
        run_cycle();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [NS-1:0] s);
        valid = 1'b1;
        spin  = s;
        run_cycle();
        valid = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        cfg_we  = 1'b0;
        valid   = 1'b0;
        tx_idle = 1'b1;
        load_n  = '0;
        cmpt_n  = '0;
        spin    = '0;
        model_reset();
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_spin", 64'(aspin), 64'(0));
        check_eq("rst_idle", 64'(idle_o), 64'(1));
        check_eq("rst_strobes", 64'({load_o, cmpt_o, fin_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic run N=4 M=10.
        configure(4, 10);
        clear_obs();
        send({4{8'hA5}});
        run_n(25);
        check_eq("basic_load_len", 64'(load_cnt), 64'(4));
        check_eq("basic_cmpt_len", 64'(cmpt_cnt), 64'(10));
        check_eq("basic_fin_cnt", 64'(fin_cnt), 64'(1));
        check_eq("basic_fin_at", 64'(fin_cyc - hs_cyc), 64'(15));

        // Zero config behaves as one cycle per phase.
        configure(0, 0);
        clear_obs();
        send(32'h1234_5678);
        run_n(10);
        check_eq("zero_load_len", 64'(load_cnt), 64'(1));
        check_eq("zero_cmpt_len", 64'(cmpt_cnt), 64'(1));
        check_eq("zero_fin_at", 64'(fin_cyc - hs_cyc), 64'(3));

        // Backpressure from the TX stage.
        clear_obs();
        tx_idle = 1'b0;
        valid   = 1'b1;
        spin    = 32'hDEAD_BEEF;
        run_n(8);
        check_eq("bp_ready_low", 64'(ready_cnt), 64'(0));
        tx_idle = 1'b1;
        run_cycle();
        valid = 1'b0;
        check_eq("bp_handshake", 64'(hs_cyc >= 0), 64'(1));
        run_n(10);

        // Enable drop in the middle of CMPT.
        configure(4, 10);
        clear_obs();
        send(32'h0F0F_0F0F);
        run_n(7);
        en = 1'b0;
        run_cycle();
        en = 1'b1;
        run_n(20);
        check_eq("endrop_no_fin", 64'(fin_cnt), 64'(0));
        clear_obs();
        send(32'hF0F0_F0F0);
        run_n(25);
        check_eq("endrop_rerun_load", 64'(load_cnt), 64'(4));
        check_eq("endrop_rerun_cmpt", 64'(cmpt_cnt), 64'(10));
        check_eq("endrop_rerun_fin", 64'(fin_cyc - hs_cyc), 64'(15));

        // Config change during LOAD applies to this run's CMPT.
        configure(6, 5);
        clear_obs();
        send(32'hCAFE_0001);
        run_n(2);
        configure(6, 20);
        run_n(40);
        check_eq("midload_cmpt", 64'(cmpt_cnt), 64'(20));
        // Config change during CMPT does not.
        clear_obs();
        send(32'hCAFE_0002);
        run_n(9);
        configure(6, 3);
        run_n(35);
        check_eq("midcmpt_cmpt", 64'(cmpt_cnt), 64'(20));

        // Asynchronous reset in the middle of LOAD.
        configure(50, 2);
        send(32'h5555_AAAA);
        run_n(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_spin", 64'(aspin), 64'(0));
        check_eq("arst_idle", 64'(idle_o), 64'(1));
        check_eq("arst_strobes", 64'({load_o, cmpt_o, fin_o}), 64'(0));
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        send(32'h7777_1111);
        run_n(520);
        check_eq("arst_cfg_load", 64'(load_cnt), 64'(255));
        check_eq("arst_cfg_cmpt", 64'(cmpt_cnt), 64'(255));
        check_eq("arst_cfg_fin", 64'(fin_cyc - hs_cyc), 64'(511));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 39) != 0);
            cfg_we  = ($urandom_range(0, 14) == 0);
            load_n  = CW'($urandom_range(0, 6));
            cmpt_n  = CW'($urandom_range(0, 6));
            valid   = ($urandom_range(0, 2) != 0);
            spin    = NS'($urandom);
            tx_idle = ($urandom_range(0, 4) != 0);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/analog_rx.md
Name: analog_rx

Overview:
- Upstream neighbour of the analog TX stage; receives one spin vector per iteration from the digital core over a valid/ready handshake.
- Drives that vector into the analog Ising macro and sequences the load and compute phases with programmable cycle counts.
- Issues the one-cycle compute-finish pulse the TX stage uses to capture and synchronise macro spins.
- Blocks new spins until the TX stage has delivered the previous result.

Parameters:
- NUM_SPIN, 256, spin vector width.
- CYCLE_W, 16, width of the load/compute cycle counters and their config inputs.
- SYNCHRONIZER_PIPEDEPTH, 3, must equal the TX stage setting; sets the post-finish holdoff length.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  block enable.
- rx_configure_enable_i  in  1  config write strobe.
- load_cycle_num_i  in  CYCLE_W  LOAD phase length in cycles.
- cmpt_cycle_num_i  in  CYCLE_W  CMPT phase length in cycles.
- spin_valid_i  in  1  digital spin valid.
- spin_ready_o  out  1  ready to accept a spin.
- spin_i  in  NUM_SPIN  spin vector from digital.
- analog_spin_o  out  NUM_SPIN  spins driven to the macro.
- analog_spin_load_o  out  1  macro spin-load strobe.
- analog_cmpt_en_o  out  1  macro compute enable.
- analog_macro_cmpt_finish_o  out  1  one-cycle finish pulse to TX.
- analog_tx_idle_i  in  1  TX idle (TX spin_valid low).
- analog_rx_idle_o  out  1  high only in IDLE.

Behaviour:
- Config registers
  - load_cycle_num_reg and cmpt_cycle_num_reg are written when en_i & rx_configure_enable_i.
  - Reset value is all ones.
  - A value of 0 is treated as 1.
  - Counters load from these registers on phase entry, so a config write mid-operation affects only phases entered after the write.
- Spin register
  - Captured from spin_i on handshake (spin_valid_i & spin_ready_o).
  - Reset value is 0.
  - Drives analog_spin_o continuously and holds its value until the next handshake.
- FSM states: IDLE, LOAD, CMPT, FINISH, HOLD. Reset state is IDLE.
- IDLE
  - spin_ready_o = en_i & analog_tx_idle_i.
  - On handshake: capture spin, load the counter with max(load_cycle_num_reg,1), go to LOAD.
- LOAD
  - analog_spin_load_o = 1.
  - Counter decrements each cycle. When the counter equals 1, load it with max(cmpt_cycle_num_reg,1) and go to CMPT.
  - With N configured, LOAD lasts exactly N cycles.
- CMPT
  - analog_cmpt_en_o = 1 for exactly max(M,1) cycles, then go to FINISH.
- FINISH
  - Lasts one cycle with analog_macro_cmpt_finish_o = 1 and analog_cmpt_en_o = 0.
  - Load the holdoff counter with SYNCHRONIZER_PIPEDEPTH+1, go to HOLD.
- HOLD
  - Count down SYNCHRONIZER_PIPEDEPTH+1 cycles, then go to IDLE.
  - Purpose: guarantees the TX valid has risen before analog_tx_idle_i is sampled again.
- Latency
  - Handshake to finish pulse: N+M+1 cycles. The finish pulse occurs in cycle N+M+1 after the handshake cycle.
  - Earliest next handshake: N+M+1+PIPEDEPTH+2 cycles after the previous handshake, and only if TX is idle.
- Enable
  - en_i low in any state: next state is IDLE and counters clear.
  - All strobes, spin_ready_o and the finish pulse deassert combinationally.
  - Config and spin registers hold their values.
- Reset mid-operation: asynchronous return to IDLE with all outputs at reset values.
  - analog_spin_o = 0.
  - All 1-bit outputs = 0, except analog_rx_idle_o = 1.
- spin_valid_i while not in IDLE is ignored; spin_ready_o stays 0.
- A config write in the same cycle as a handshake: the LOAD counter uses the old value; CMPT uses the new value.
- Strobes are mutually exclusive. At most one of analog_spin_load_o, analog_cmpt_en_o and analog_macro_cmpt_finish_o is high in any cycle.

Test Plan:
- Basic: reset, configure N=4, M=10, send spin 0xA5…A5 with TX idle.
  - Load strobe high exactly 4 cycles, compute high exactly 10 cycles.
  - Finish pulse 1 cycle at handshake+15; analog_spin_o = 0xA5…A5 throughout.
- Zero config: N=0, M=0.
  - Each phase lasts 1 cycle; finish pulse at handshake+3.
- Backpressure: hold analog_tx_idle_i=0 after HOLD, spin_valid_i=1.
  - spin_ready_o stays 0; ready rises the cycle TX idle returns; handshake completes.
- Enable drop: deassert en_i mid-CMPT for 1 cycle.
  - Compute strobe drops immediately and the FSM goes to IDLE with no finish pulse.
  - Next handshake restarts the full N+M sequence with the retained config.
- Async reset: assert rst_ni low mid-LOAD between clock edges.
  - Outputs clear immediately; config registers return to all ones (load strobe lasts 2^CYCLE_W-1 cycles on the next run).
- Mid-op config: write M=20 during LOAD of a run configured M=5.
  - That run's CMPT lasts 20 cycles.
  - A write during CMPT does not change that run's CMPT length.
